pieo_sublist_engine: RTL and testbench

Parametrised, self-contained PIEO sublist: a sorted array of up to DEPTH `{id, rank, send_time}` entries, ordered by ascending rank, with FIFO order among equal ranks. It accepts one enqueue or one extract per operation. An extract returns the smallest-rank element whose send_time has arrived. The block also publishes the per-sublist summary that the pointer-list level of the PIEO scheduler consumes: smallest rank, smallest send time, full flag and count. This is the building block the pointer array will instantiate once per sublist.

---
 rtl/pieo_sublist_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_pieo_sublist_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pieo_sublist_engine.sv
// pieo_sublist_engine: one PIEO sublist. It holds up to DEPTH {id, rank, send_time}
// entries sorted by ascending rank, with FIFO order among equal ranks. It performs
// one enqueue or one extract every two cycles. It publishes the summary consumed by
// the pointer level: smallest rank, smallest send time, full flag and count.
// Optional feature macro: PIEO_ELIGIBILITY_EN
//   - defined:   an extract takes the lowest-index entry with send_time <= cur_time
//   - undefined: PIFO behaviour; an extract takes entry 0 and cur_time is ignored
module pieo_sublist_engine #(
    parameter int ID_LOG   = 10,
    parameter int RANK_LOG = 16,
    parameter int TIME_LOG = 16,
    parameter int DEPTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TIME_LOG-1:0]        cur_time,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [ID_LOG-1:0]          enq_id,
    input  logic [RANK_LOG-1:0]        enq_rank,
    input  logic [TIME_LOG-1:0]        enq_send_time,
    input  logic                       deq_valid,
    output logic                       deq_ready,
    output logic                       resp_valid,
    output logic                       resp_found,
    output logic [ID_LOG-1:0]          resp_id,
    output logic [RANK_LOG-1:0]        resp_rank,
    output logic [TIME_LOG-1:0]        resp_send_time,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [RANK_LOG-1:0]        smallest_rank,
    output logic [TIME_LOG-1:0]        smallest_send_time
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int LV = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ENQ, DEQ} state_t;

    state_t              state_reg;
    logic [CW-1:0]       count_reg;
    logic [ID_LOG-1:0]   req_id_reg;
    logic [RANK_LOG-1:0] req_rank_reg;
    logic [TIME_LOG-1:0] req_st_reg;
    logic                resp_valid_reg;
    logic                resp_found_reg;
    logic [ID_LOG-1:0]   resp_id_reg;
    logic [RANK_LOG-1:0] resp_rank_reg;
    logic [TIME_LOG-1:0] resp_st_reg;

    // Flattened view of the per-entry registers below
    logic [ID_LOG-1:0]   id_arr   [DEPTH];
    logic [RANK_LOG-1:0] rank_arr [DEPTH];
    logic [TIME_LOG-1:0] st_arr   [DEPTH];

    logic [DEPTH-1:0] valid_mask;
    logic [DEPTH-1:0] gt_mask;
    logic [DEPTH-1:0] elig_mask;
    logic [CW-1:0]    ins_pos;
    logic [IW-1:0]    ext_pos;
    logic             ext_found;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign deq_ready = (state_reg == IDLE);
    assign enq_ready = (state_reg == IDLE) && !full && !deq_valid;

    assign resp_valid     = resp_valid_reg;
    assign resp_found     = resp_found_reg;
    assign resp_id        = resp_id_reg;
    assign resp_rank      = resp_rank_reg;
    assign resp_send_time = resp_st_reg;
    assign smallest_rank  = rank_arr[0];

    genvar gi, gl;

    // Per-entry match vectors: strictly-greater rank for insert, eligibility for extract
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign valid_mask[gi] = (CW'(gi) < count_reg);
        assign gt_mask[gi]    = valid_mask[gi] && (rank_arr[gi] > req_rank_reg);
`ifdef PIEO_ELIGIBILITY_EN
        assign elig_mask[gi]  = valid_mask[gi] && (st_arr[gi] <= cur_time);
`else
        if (gi == 0) begin : g_head
            assign elig_mask[gi] = valid_mask[gi];
        end else begin : g_rest
            assign elig_mask[gi] = 1'b0;
        end
`endif
    end

`ifndef PIEO_ELIGIBILITY_EN
    // In PIFO mode the current time has no effect on extraction
    logic unused_cur_time;
    assign unused_cur_time = ^cur_time;
`endif

    assign ext_found = |elig_mask;

    // Insert position is the first entry ranked strictly above the new one, else the tail
    always_comb begin
        ins_pos = count_reg;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (gt_mask[i]) ins_pos = CW'(i);
        end
    end

    // Extract position is the lowest eligible index
    always_comb begin
        ext_pos = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig_mask[i]) ext_pos = IW'(i);
        end
    end

    // Storage entries: each one loads the new element, its lower neighbour or its upper neighbour
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [ID_LOG-1:0]   id_reg;
        logic [RANK_LOG-1:0] rank_reg;
        logic [TIME_LOG-1:0] st_reg;
        logic [ID_LOG-1:0]   lo_id,   hi_id;
        logic [RANK_LOG-1:0] lo_rank, hi_rank;
        logic [TIME_LOG-1:0] lo_st,   hi_st;

        if (gi == 0) begin : g_lo_edge
            assign lo_id   = '0;
            assign lo_rank = '1;
            assign lo_st   = '1;
        end else begin : g_lo
            assign lo_id   = id_arr[gi-1];
            assign lo_rank = rank_arr[gi-1];
            assign lo_st   = st_arr[gi-1];
        end

        if (gi == DEPTH - 1) begin : g_hi_edge
            assign hi_id   = '0;
            assign hi_rank = '1;
            assign hi_st   = '1;
        end else begin : g_hi
            assign hi_id   = id_arr[gi+1];
            assign hi_rank = rank_arr[gi+1];
            assign hi_st   = st_arr[gi+1];
        end

        // Shift up on enqueue (positions above the insert point), shift down on a found extract
        always_ff @(posedge clk) begin
            if (rst) begin
                id_reg   <= '0;
                rank_reg <= '1;
                st_reg   <= '1;
            end else if (state_reg == ENQ) begin
                if (CW'(gi) == ins_pos) begin
                    id_reg   <= req_id_reg;
                    rank_reg <= req_rank_reg;
                    st_reg   <= req_st_reg;
                end else if ((CW'(gi) > ins_pos) && (CW'(gi) <= count_reg)) begin
                    id_reg   <= lo_id;
                    rank_reg <= lo_rank;
                    st_reg   <= lo_st;
                end
            end else if ((state_reg == DEQ) && ext_found && (IW'(gi) >= ext_pos)) begin
                id_reg   <= hi_id;
                rank_reg <= hi_rank;
                st_reg   <= hi_st;
            end
        end

        assign id_arr[gi]   = id_reg;
        assign rank_arr[gi] = rank_reg;
        assign st_arr[gi]   = st_reg;
    end

    // Min-reduction tree over send_time; invalid entries are infinity so they never win
    for (gl = 0; gl <= LV; gl++) begin : g_lvl
        localparam int N = DEPTH >> gl;
        logic [TIME_LOG-1:0] node [N];
        for (gi = 0; gi < N; gi++) begin : g_node
            if (gl == 0) begin : g_leaf
                assign node[gi] = st_arr[gi];
            end else begin : g_min
                logic [TIME_LOG-1:0] a_st, b_st;
                assign a_st     = g_lvl[gl-1].node[2*gi];
                assign b_st     = g_lvl[gl-1].node[2*gi+1];
                assign node[gi] = (a_st <= b_st) ? a_st : b_st;
            end
        end
    end
    assign smallest_send_time = g_lvl[LV].node[0];

    // Control FSM: request capture, count bookkeeping and the registered extract response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            req_id_reg     <= '0;
            req_rank_reg   <= '0;
            req_st_reg     <= '0;
            resp_valid_reg <= 1'b0;
            resp_found_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_rank_reg  <= '0;
            resp_st_reg    <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (deq_valid) begin
                        state_reg <= DEQ;
                    end else if (enq_valid && !full) begin
                        state_reg    <= ENQ;
                        req_id_reg   <= enq_id;
                        req_rank_reg <= enq_rank;
                        req_st_reg   <= enq_send_time;
                    end
                end
                ENQ: begin
                    state_reg <= IDLE;
                    count_reg <= count_reg + 1'b1;
                end
                DEQ: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b1;
                    resp_found_reg <= ext_found;
                    if (ext_found) begin
                        count_reg     <= count_reg - 1'b1;
                        resp_id_reg   <= id_arr[ext_pos];
                        resp_rank_reg <= rank_arr[ext_pos];
                        resp_st_reg   <= st_arr[ext_pos];
                    end else begin
                        resp_id_reg   <= '0;
                        resp_rank_reg <= '0;
                        resp_st_reg   <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pieo_sublist_engine.sv
// Testbench for pieo_sublist_engine: a queue-based reference model with a per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
module tb_pieo_sublist_engine;
    localparam int ID_LOG   = 10;
    localparam int RANK_LOG = 16;
    localparam int TIME_LOG = 16;
    localparam int DEPTH    = 16;
    localparam int CW       = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [TIME_LOG-1:0] cur_time = '0;
    logic                enq_valid = 1'b0;
    logic                enq_ready;
    logic [ID_LOG-1:0]   enq_id = '0;
    logic [RANK_LOG-1:0] enq_rank = '0;
    logic [TIME_LOG-1:0] enq_send_time = '0;
    logic                deq_valid = 1'b0;
    logic                deq_ready;
    logic                resp_valid;
    logic                resp_found;
    logic [ID_LOG-1:0]   resp_id;
    logic [RANK_LOG-1:0] resp_rank;
    logic [TIME_LOG-1:0] resp_send_time;
    logic [CW-1:0]       count;
    logic                full;
    logic                empty;
    logic [RANK_LOG-1:0] smallest_rank;
    logic [TIME_LOG-1:0] smallest_send_time;

    pieo_sublist_engine #(
        .ID_LOG(ID_LOG), .RANK_LOG(RANK_LOG), .TIME_LOG(TIME_LOG), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .cur_time(cur_time),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_id(enq_id), .enq_rank(enq_rank), .enq_send_time(enq_send_time),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .resp_valid(resp_valid), .resp_found(resp_found),
        .resp_id(resp_id), .resp_rank(resp_rank), .resp_send_time(resp_send_time),
        .count(count), .full(full), .empty(empty),
        .smallest_rank(smallest_rank), .smallest_send_time(smallest_send_time)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [ID_LOG-1:0]   id;
        logic [RANK_LOG-1:0] rank;
        logic [TIME_LOG-1:0] st;
    } ent_t;

    ent_t mq[$];
    int   pend = 0;          // 0 none, 1 enqueue in flight, 2 extract in flight
    ent_t pend_e = '0;
    logic m_rv = 1'b0;
    logic m_found = 1'b0;
    ent_t m_resp = '0;

    // Advance the model at each clock edge from the inputs the bench is driving
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                pend    = 0;
                m_rv    = 1'b0;
                m_found = 1'b0;
                m_resp  = '0;
            end else if (pend == 1) begin
                int p;
                p = mq.size();
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].rank > pend_e.rank) begin
                        p = i;
                        break;
                    end
                end
                mq.insert(p, pend_e);
                pend = 0;
                m_rv = 1'b0;
            end else if (pend == 2) begin
                int q;
                q = -1;
`ifdef PIEO_ELIGIBILITY_EN
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].st <= cur_time) begin
                        q = i;
                        break;
                    end
                end
`else
                if (mq.size() > 0) q = 0;
`endif
                if (q >= 0) begin
                    m_found = 1'b1;
                    m_resp  = mq[q];
                    mq.delete(q);
                end else begin
                    m_found = 1'b0;
                    m_resp  = '0;
                end
                pend = 0;
                m_rv = 1'b1;
            end else begin
                m_rv = 1'b0;
                if (deq_valid) begin
                    pend = 2;
                end else if (enq_valid && mq.size() < DEPTH) begin
                    pend   = 1;
                    pend_e = '{id: enq_id, rank: enq_rank, st: enq_send_time};
                end
            end
        end
    end

    // Compare every DUT output against the model once per cycle, away from the active edge
    initial begin
        logic [RANK_LOG-1:0] er;
        logic [TIME_LOG-1:0] es;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            er = '1;
            es = '1;
            if (mq.size() > 0) er = mq[0].rank;
            foreach (mq[i]) if (mq[i].st < es) es = mq[i].st;
            chk("count", 32'(count), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("smallest_rank", 32'(smallest_rank), 32'(er));
            chk("smallest_send_time", 32'(smallest_send_time), 32'(es));
            chk("deq_ready", 32'(deq_ready), 32'(pend == 0));
            chk("enq_ready", 32'(enq_ready), 32'((pend == 0) && (mq.size() < DEPTH) && !deq_valid));
            chk("resp_valid", 32'(resp_valid), 32'(m_rv));
            chk("resp_found", 32'(resp_found), 32'(m_found));
            chk("resp_id", 32'(resp_id), 32'(m_resp.id));
            chk("resp_rank", 32'(resp_rank), 32'(m_resp.rank));
            chk("resp_send_time", 32'(resp_send_time), 32'(m_resp.st));
        end
    end

    // ---------------- directed helpers ----------------
    // Each helper starts just after a falling edge and returns 1 time unit after the
    // falling edge on which the operation's result is visible.
    task automatic do_enq(input int id, input int rank, input int st);
        enq_valid     = 1'b1;
        enq_id        = ID_LOG'(id);
        enq_rank      = RANK_LOG'(rank);
        enq_send_time = TIME_LOG'(st);
        @(negedge clk);
        enq_valid = 1'b0;
        @(negedge clk);
        #1;
        $display("enq id=%0d rank=%0d st=%0d -> count=%0d", id, rank, st, count);
    endtask

    task automatic do_deq(input int ct);
        cur_time  = TIME_LOG'(ct);
        deq_valid = 1'b1;
        @(negedge clk);
        deq_valid = 1'b0;
        @(negedge clk);
        #1;
        $display("deq cur_time=%0d -> valid=%0d found=%0d id=%0d count=%0d",
                 ct, resp_valid, resp_found, resp_id, count);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int id_ctr = 0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_smallest_rank", 32'(smallest_rank), 32'h0000_ffff);
        chk("rst_smallest_st", 32'(smallest_send_time), 32'h0000_ffff);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        chk("rst_deq_ready", 32'(deq_ready), 1);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // Basic ordering
        do_enq(1, 30, 0);
        do_enq(2, 10, 0);
        do_enq(3, 20, 0);
        chk("basic_count3", 32'(count), 3);
        chk("basic_smallest_rank", 32'(smallest_rank), 10);
        do_deq(0);
        chk("basic_id_a", 32'(resp_id), 2);
        chk("basic_count2", 32'(count), 2);
        do_deq(0);
        chk("basic_id_b", 32'(resp_id), 3);
        do_deq(0);
        chk("basic_id_c", 32'(resp_id), 1);
        chk("basic_count0", 32'(count), 0);
        chk("basic_empty", 32'(empty), 1);

        // FIFO order among equal ranks
        do_enq(5, 7, 0);
        do_enq(6, 7, 0);
        do_deq(0);
        chk("tie_first", 32'(resp_id), 5);
        do_deq(0);
        chk("tie_second", 32'(resp_id), 6);

        // Eligibility
        do_enq(1, 1, 100);
        do_enq(2, 9, 5);
        chk("elig_min_st", 32'(smallest_send_time), 5);
        do_deq(10);
`ifdef PIEO_ELIGIBILITY_EN
        chk("elig_id", 32'(resp_id), 2);
        chk("elig_found", 32'(resp_found), 1);
        chk("elig_min_st_after", 32'(smallest_send_time), 100);
        do_deq(50);
        chk("elig_notfound", 32'(resp_found), 0);
        chk("elig_count_kept", 32'(count), 1);
        do_deq(100);
        chk("elig_late_id", 32'(resp_id), 1);
`else
        chk("pifo_id", 32'(resp_id), 1);
        chk("pifo_min_st_after", 32'(smallest_send_time), 5);
        do_deq(50);
        chk("pifo_second_id", 32'(resp_id), 2);
        do_deq(100);
`endif
        // Extract on empty
        do_deq(100);
        chk("empty_valid", 32'(resp_valid), 1);
        chk("empty_found", 32'(resp_found), 0);
        chk("empty_id", 32'(resp_id), 0);
        chk("empty_count", 32'(count), 0);

        // Fill with enq_valid held high
        enq_valid = 1'b1;
        for (int k = 0; k < 2 * DEPTH + 4; k++) begin
            enq_id        = ID_LOG'(100 + k);
            enq_rank      = RANK_LOG'((k * 7) % 13);
            enq_send_time = TIME_LOG'(k);
            @(negedge clk);
        end
        #1;
        chk("full_flag", 32'(full), 1);
        chk("full_enq_ready", 32'(enq_ready), 0);
        chk("full_count", 32'(count), DEPTH);

        // Extract from full while enq_valid stays high; resp two cycles after handshake
        cur_time  = TIME_LOG'(200);
        deq_valid = 1'b1;
        #1;
        chk("hs_deq_ready", 32'(deq_ready), 1);
        @(negedge clk);
        deq_valid = 1'b0;
        #1;
        chk("hs_resp_not_yet", 32'(resp_valid), 0);
        chk("hs_enq_busy", 32'(enq_ready), 0);
        @(negedge clk);
        #1;
        chk("hs_resp_pulse", 32'(resp_valid), 1);
        chk("hs_count", 32'(count), DEPTH - 1);
        chk("hs_enq_ready", 32'(enq_ready), 1);
        // Both requests in IDLE: extract wins, enqueue waits
        deq_valid = 1'b1;
        #1;
        chk("both_enq_ready", 32'(enq_ready), 0);
        @(negedge clk);
        deq_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("both_resp", 32'(resp_valid), 1);
        chk("both_count", 32'(count), DEPTH - 2);
        @(negedge clk);
        enq_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("stalled_enq_done", 32'(count), DEPTH - 1);

        // Reset during the ENQ cycle
        do_enq(7, 3, 3);
        enq_valid = 1'b1;
        enq_id    = 10'd9;
        enq_rank  = 16'd1;
        @(negedge clk);
        enq_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_enq_resp", 32'(resp_valid), 0);
        chk("rst_enq_count", 32'(count), 0);
        chk("rst_enq_rank", 32'(smallest_rank), 32'h0000_ffff);
        rst = 1'b0;

        // Random traffic against the model
        cur_time = TIME_LOG'(300);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 399) == 0);
            enq_valid = ($urandom_range(0, 99) < 60);
            deq_valid = ($urandom_range(0, 99) < 30);
            id_ctr++;
            enq_id    = ID_LOG'(id_ctr);
            enq_rank  = ($urandom_range(0, 19) == 0) ? 16'hffff : RANK_LOG'($urandom_range(0, 15));
            cur_time  = cur_time + TIME_LOG'($urandom_range(0, 1));
            enq_send_time = cur_time + TIME_LOG'($urandom_range(0, 30));
            if (resp_valid)
                $display("rand resp found=%0d id=%0d rank=%0d st=%0d count=%0d",
                         resp_found, resp_id, resp_rank, resp_send_time, count);
        end
        @(negedge clk);
        rst       = 1'b0;
        enq_valid = 1'b0;
        deq_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
